slice_seq: RTL

SLICE_SEQ -- requirements
Module: slice_seq

---
 rtl/slice_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/slice_seq.sv
// Micro-sequencer for the bit-slice datapath: fetch, operand, indirect
// and execute phases with a request/acknowledge memory handshake.
module slice_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_run,
    input  logic [7:0] ir_in,
    input  logic       mem_ack,
    input  logic       a_zero,
    output logic       mem_req,
    output logic       mem_we,
    output logic       rdp,
    output logic       incp_clk,
    output logic       wrx,
    output logic       rdx,
    output logic       wra,
    output logic       rda,
    output logic       wrs,
    output logic       nwrp,
    output logic [1:0] xin_sel,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_OPND  = 3'd2,
        S_INDIR = 3'd3,
        S_EXEC  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] ir_q, ir_d;
    logic       done;
    logic       unused_ir;

    // only opcode and deref are kept; the low nibble is operand data
    assign unused_ir = ^ir_in[3:0];

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        done     = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        rdp      = 1'b0;
        incp_clk = 1'b0;
        wrx      = 1'b0;
        rdx      = 1'b0;
        wra      = 1'b0;
        rda      = 1'b0;
        wrs      = 1'b0;
        nwrp     = 1'b1;
        xin_sel  = 2'd0;
        alu_op   = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (sw_run) state_d = S_FETCH;
            end
            S_FETCH: begin
                rdp     = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_d     = ir_in[7:4];
                    incp_clk = 1'b1;
                    state_d  = S_OPND;
                end
            end
            S_OPND: begin
                rdp     = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    wrx      = 1'b1;
                    xin_sel  = 2'd3;
                    incp_clk = 1'b1;
                    state_d  = ir_q[0] ? S_INDIR : S_EXEC;
                end
            end
            S_INDIR: begin
                rdx     = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    wrx     = 1'b1;
                    xin_sel = 2'd3;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (ir_q[3:1])
                    3'b000: begin
                        rdx     = 1'b1;
                        mem_req = 1'b1;
                        wra     = mem_ack;
                        done    = mem_ack;
                    end
                    3'b001: begin
                        rdx     = 1'b1;
                        rda     = 1'b1;
                        mem_req = 1'b1;
                        mem_we  = 1'b1;
                        done    = mem_ack;
                    end
                    3'b010, 3'b011: begin
                        rdx     = 1'b1;
                        mem_req = 1'b1;
                        if (mem_ack) begin
                            wra    = 1'b1;
                            wrs    = 1'b1;
                            alu_op = ir_q[1] ? 2'd2 : 2'd1;
                            done   = 1'b1;
                        end
                    end
                    3'b100: begin
                        rdx  = 1'b1;
                        nwrp = 1'b0;
                        done = 1'b1;
                    end
                    3'b101: begin
                        rdx  = a_zero;
                        nwrp = ~a_zero;
                        done = 1'b1;
                    end
                    3'b110: begin
                        wra    = 1'b1;
                        alu_op = 2'd3;
                        done   = 1'b1;
                    end
                    default: state_d = S_HALT;
                endcase
                if (done) state_d = sw_run ? S_FETCH : S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        // a late ack during reset must not fire any strobe
        if (rst) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            rdp      = 1'b0;
            incp_clk = 1'b0;
            wrx      = 1'b0;
            rdx      = 1'b0;
            wra      = 1'b0;
            rda      = 1'b0;
            wrs      = 1'b0;
            nwrp     = 1'b1;
            xin_sel  = 2'd0;
            alu_op   = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign halted = (state_q == S_HALT);
    assign state  = state_q;

endmodule
